// File: rtl/ldmx_reg_responder.sv
// Strobe/ack register responder: services level read/write strobes against a local
// bank of RW control words, RO status words, an error counter and a pulse register.
module ldmx_reg_responder #(
    parameter int          NREG        = 16,
    parameter int          NSTAT       = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] CTRL_RESET  = 32'h0
) (
    input  logic                  axilClk,
    input  logic                  axilRstL,
    input  logic [7:0]            addr,
    input  logic [31:0]           wdata,
    input  logic                  wstr,
    input  logic                  rstr,
    output logic                  wack,
    output logic                  rack,
    output logic [31:0]           dout,
    output logic [32*NREG-1:0]    ctrl_out,
    input  logic [32*NSTAT-1:0]   stat_in,
    output logic [31:0]           pulse_out
);

    localparam logic [7:0]  STAT_BASE     = 8'h40;
    localparam logic [7:0]  ERR_ADDR      = 8'h7E;
    localparam logic [7:0]  PULSE_ADDR    = 8'h7F;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF;
    localparam logic [3:0]  WAIT_LOAD     = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic          op_wr_q, op_wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   err_q, err_d;
    logic [31:0]   ctrl_q [NREG];
    logic [31:0]   ctrl_d [NREG];
    logic          wack_q, wack_d;
    logic          rack_q, rack_d;
    logic [31:0]   dout_q, dout_d;
    logic [31:0]   pulse_q, pulse_d;

    logic [7:0]    acc_addr;
    logic [31:0]   acc_wdata;
    logic          hit_ctrl;
    logic          hit_stat;
    logic          hit_err;
    logic          hit_pulse;
    logic [31:0]   rd_word;
    logic [15:0]   err_inc;
    logic          op_stb;
    logic          commit;
    logic          commit_wr;

    // With no wait states the commit happens on the very edge that samples the
    // strobe, so the access uses the live bus instead of the latched copy.
    always_comb begin
        acc_addr  = (state_q == S_IDLE) ? addr  : addr_q;
        acc_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
        hit_ctrl  = 1'b0;
        hit_stat  = 1'b0;
        hit_err   = (acc_addr == ERR_ADDR);
        hit_pulse = (acc_addr == PULSE_ADDR);
        rd_word   = UNMAPPED_DATA;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (acc_addr == 8'(i)) begin
                hit_ctrl = 1'b1;
                rd_word  = ctrl_q[i];
            end
        end
        for (int unsigned i = 0; i < NSTAT; i++) begin
            if (acc_addr == STAT_BASE + 8'(i)) begin
                hit_stat = 1'b1;
                rd_word  = stat_in[32*i +: 32];
            end
        end
        if (hit_err) begin
            rd_word = {16'h0, err_q};
        end
        if (hit_pulse) begin
            rd_word = '0;
        end
        err_inc = (err_q == '1) ? err_q : err_q + 16'd1;
    end

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wack_d    = 1'b0;
        rack_d    = 1'b0;
        dout_d    = '0;
        pulse_d   = '0;
        commit    = 1'b0;
        commit_wr = 1'b0;
        op_stb    = op_wr_q ? wstr : rstr;
        for (int unsigned i = 0; i < NREG; i++) begin
            ctrl_d[i] = ctrl_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (wstr || rstr) begin
                    op_wr_d = wstr;
                    addr_d  = addr;
                    if (wstr) begin
                        wdata_d = wdata;
                    end
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_ACK;
                        commit    = 1'b1;
                        commit_wr = wstr;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!op_stb) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d   = S_ACK;
                    commit    = 1'b1;
                    commit_wr = op_wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!op_stb) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            if (commit_wr) begin
                wack_d = 1'b1;
                if (hit_ctrl) begin
                    for (int unsigned i = 0; i < NREG; i++) begin
                        if (acc_addr == 8'(i)) begin
                            ctrl_d[i] = acc_wdata;
                        end
                    end
                end else if (hit_err) begin
                    err_d = '0;
                end else if (hit_pulse) begin
                    pulse_d = acc_wdata;
                end else begin
                    err_d = err_inc;
                end
            end else begin
                rack_d = 1'b1;
                dout_d = rd_word;
                if (!(hit_ctrl || hit_stat || hit_err || hit_pulse)) begin
                    err_d = err_inc;
                end
            end
        end
    end

    always_ff @(posedge axilClk or negedge axilRstL) begin
        if (!axilRstL) begin
            state_q <= S_IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            wack_q  <= 1'b0;
            rack_q  <= 1'b0;
            dout_q  <= '0;
            pulse_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                ctrl_q[i] <= CTRL_RESET;
            end
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wack_q  <= wack_d;
            rack_q  <= rack_d;
            dout_q  <= dout_d;
            pulse_q <= pulse_d;
            for (int unsigned i = 0; i < NREG; i++) begin
                ctrl_q[i] <= ctrl_d[i];
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_ctrl_out
        assign ctrl_out[32*g +: 32] = ctrl_q[g];
    end

    assign wack      = wack_q;
    assign rack      = rack_q;
    assign dout      = dout_q;
    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_ldmx_reg_responder.sv
// Bench for ldmx_reg_responder: two instances (0 and 3 wait states) driven by directed
// transactions, checked every cycle against a transaction-level model plus literal checks.
`timescale 1ns/1ps
module tb_ldmx_reg_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   addr [2];
    logic [31:0]  wdata [2];
    logic         wstr [2];
    logic         rstr [2];
    logic         wack [2];
    logic         rack [2];
    logic [31:0]  dout [2];
    logic [31:0]  pulse [2];
    logic [511:0] ctrl_out [2];
    logic [255:0] stat_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ldmx_reg_responder #(.NREG(16), .NSTAT(8), .WAIT_CYCLES(0), .CTRL_RESET(32'h0)) u_dut0 (
        .axilClk(clk), .axilRstL(rst_n), .addr(addr[0]), .wdata(wdata[0]),
        .wstr(wstr[0]), .rstr(rstr[0]), .wack(wack[0]), .rack(rack[0]), .dout(dout[0]),
        .ctrl_out(ctrl_out[0]), .stat_in(stat_in), .pulse_out(pulse[0])
    );

    ldmx_reg_responder #(.NREG(16), .NSTAT(8), .WAIT_CYCLES(3), .CTRL_RESET(32'h0)) u_dut1 (
        .axilClk(clk), .axilRstL(rst_n), .addr(addr[1]), .wdata(wdata[1]),
        .wstr(wstr[1]), .rstr(rstr[1]), .wack(wack[1]), .rack(rack[1]), .dout(dout[1]),
        .ctrl_out(ctrl_out[1]), .stat_in(stat_in), .pulse_out(pulse[1])
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] stat_word(input int i);
        return 32'hA500_0000 + 32'h11 * i;
    endfunction

    // Transaction-level model: ack due a fixed number of edges after acceptance,
    // responder free again once the strobe is seen low two or more edges after the ack.
    longint      cyc;
    bit          m_pend [2];
    bit          m_hold [2];
    bit          m_wr [2];
    logic [7:0]  m_a [2];
    logic [31:0] m_wd [2];
    longint      m_due [2];
    longint      m_rel [2];
    logic [31:0] m_ctrl [2][16];
    int          m_err [2];
    logic        m_wack [2];
    logic        m_rack [2];
    logic [31:0] m_dout [2];
    logic [31:0] m_pulse [2];

    function automatic bit mapped(input logic [7:0] a);
        return (a < 8'd16) || (a >= 8'h40 && a < 8'h48) || a == 8'h7E || a == 8'h7F;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [7:0] a);
        if (a < 8'd16) return m_ctrl[d][a[3:0]];
        if (a >= 8'h40 && a < 8'h48) return stat_word(int'(a) - 64);
        if (a == 8'h7E) return {16'h0, m_err[d][15:0]};
        if (a == 8'h7F) return 32'h0;
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [511:0] model_ctrl(input int d);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = m_ctrl[d][i];
        return v;
    endfunction

    task automatic model_reset(input int d);
        m_pend[d] = 0; m_hold[d] = 0; m_wr[d] = 0; m_err[d] = 0;
        m_wack[d] = 0; m_rack[d] = 0; m_dout[d] = 0; m_pulse[d] = 0;
        for (int i = 0; i < 16; i++) m_ctrl[d][i] = 32'h0;
    endtask

    task automatic model_ack(input int d);
        if (m_wr[d]) begin
            m_wack[d] = 1;
            if (m_a[d] < 8'd16) m_ctrl[d][m_a[d][3:0]] = m_wd[d];
            else if (m_a[d] == 8'h7E) m_err[d] = 0;
            else if (m_a[d] == 8'h7F) m_pulse[d] = m_wd[d];
            else if (m_err[d] < 65535) m_err[d]++;
        end else begin
            m_rack[d] = 1;
            m_dout[d] = model_read(d, m_a[d]);
            if (!mapped(m_a[d]) && m_err[d] < 65535) m_err[d]++;
        end
        m_pend[d] = 0;
        m_hold[d] = 1;
        m_rel[d]  = cyc + 2;
    endtask

    task automatic model_step(input int d, input int w);
        bit stb;
        m_wack[d] = 0; m_rack[d] = 0; m_dout[d] = 0; m_pulse[d] = 0;
        stb = m_wr[d] ? wstr[d] : rstr[d];
        if (m_pend[d]) begin
            if (!stb) m_pend[d] = 0;
            else if (cyc == m_due[d]) model_ack(d);
        end else if (m_hold[d]) begin
            if (cyc >= m_rel[d] && !stb) m_hold[d] = 0;
        end else if (wstr[d] || rstr[d]) begin
            m_wr[d]   = wstr[d];
            m_a[d]    = addr[d];
            m_wd[d]   = wdata[d];
            m_pend[d] = 1;
            m_due[d]  = cyc + w;
            if (w == 0) model_ack(d);
        end
    endtask

    initial begin
        cyc = 0;
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                cyc++;
                model_step(0, 0);
                model_step(1, 3);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("wack%0d", d), wack[d], m_wack[d]);
                chk($sformatf("rack%0d", d), rack[d], m_rack[d]);
                chk($sformatf("dout%0d", d), dout[d], m_dout[d]);
                chk($sformatf("pulse%0d", d), pulse[d], m_pulse[d]);
                chk($sformatf("ctrl%0d", d), ctrl_out[d], model_ctrl(d));
            end
        end
    end

    task automatic xfer(input int d, input bit w, input logic [7:0] a, input logic [31:0] v,
                        input int hold, output int acks, output int first,
                        output logic [31:0] rd, output logic [31:0] pl);
        acks = 0; first = -1; rd = '0; pl = '0;
        @(negedge clk);
        addr[d] = a;
        wdata[d] = v;
        if (w) wstr[d] = 1'b1; else rstr[d] = 1'b1;
        for (int i = 1; i <= hold + 4; i++) begin
            @(negedge clk);
            if (w ? wack[d] : rack[d]) begin
                acks++;
                if (first < 0) first = i;
                rd = dout[d];
                pl = pulse[d];
            end
            if (i == hold) begin
                wstr[d] = 1'b0;
                rstr[d] = 1'b0;
            end
        end
    endtask

    initial begin
        int acks, first, wa, ra, rfirst;
        logic [31:0] rd, pl, rdv;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdata[d] = '0; wstr[d] = 1'b0; rstr[d] = 1'b0;
        end
        for (int i = 0; i < 8; i++) stat_in[32*i +: 32] = stat_word(i);

        repeat (3) @(negedge clk);
        chk("reset_wack", wack[0], 1'b0);
        chk("reset_dout", dout[0], 32'h0);
        chk("reset_ctrl", ctrl_out[1], 512'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        xfer(0, 1, 8'h03, 32'h12345678, 3, acks, first, rd, pl);
        chk("w03_acks", acks, 1);
        chk("w03_latency", first, 1);
        chk("w03_ctrl", ctrl_out[0][127:96], 32'h12345678);
        xfer(0, 0, 8'h03, 32'h0, 3, acks, first, rd, pl);
        chk("r03_acks", acks, 1);
        chk("r03_data", rd, 32'h12345678);

        xfer(0, 1, 8'h05, 32'hCAFE0005, 20, acks, first, rd, pl);
        chk("w05_long_acks", acks, 1);
        xfer(0, 1, 8'h05, 32'hCAFE0055, 20, acks, first, rd, pl);
        chk("w05_again_acks", acks, 1);
        chk("w05_ctrl", ctrl_out[0][191:160], 32'hCAFE0055);

        xfer(0, 1, 8'h7F, 32'h000000A5, 3, acks, first, rd, pl);
        chk("pulse_acks", acks, 1);
        chk("pulse_val", pl, 32'hA5);
        xfer(0, 0, 8'h41, 32'h0, 3, acks, first, rd, pl);
        chk("stat41", rd, 32'hA500_0011);

        xfer(0, 1, 8'h40, 32'h1, 3, acks, first, rd, pl);
        chk("w40_acked", acks, 1);
        xfer(0, 1, 8'h30, 32'h1, 3, acks, first, rd, pl);
        xfer(0, 0, 8'h50, 32'h0, 3, acks, first, rd, pl);
        chk("r50_unmapped", rd, 32'hDEADBEEF);
        xfer(0, 0, 8'h7E, 32'h0, 3, acks, first, rd, pl);
        chk("errcnt_3", rd, 32'h3);
        xfer(0, 0, 8'h30, 32'h0, 3, acks, first, rd, pl);
        chk("r30_unmapped", rd, 32'hDEADBEEF);
        xfer(0, 0, 8'h7E, 32'h0, 3, acks, first, rd, pl);
        chk("errcnt_4", rd, 32'h4);
        xfer(0, 1, 8'h7E, 32'h5A5A5A5A, 3, acks, first, rd, pl);
        xfer(0, 0, 8'h7E, 32'h0, 3, acks, first, rd, pl);
        chk("errcnt_clr", rd, 32'h0);

        // both strobes together: write first, read only once wstr has dropped
        @(negedge clk);
        addr[0] = 8'h02; wdata[0] = 32'h0BADF00D; wstr[0] = 1'b1; rstr[0] = 1'b1;
        wa = 0; ra = 0; rfirst = -1; rdv = '0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (wack[0]) wa++;
            if (rack[0]) ra++;
        end
        chk("both_wack", wa, 1);
        chk("both_no_rack", ra, 0);
        wstr[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (rack[0]) begin
                ra++;
                if (rfirst < 0) rfirst = i;
                rdv = dout[0];
            end
        end
        chk("both_rack", ra, 1);
        chk("both_rack_time", rfirst, 2);
        chk("both_rdata", rdv, 32'h0BADF00D);
        rstr[0] = 1'b0;
        repeat (3) @(negedge clk);

        xfer(1, 1, 8'h00, 32'hFFFFFFFF, 6, acks, first, rd, pl);
        chk("w1_latency", first, 4);
        chk("w1_ctrl", ctrl_out[1][31:0], 32'hFFFFFFFF);
        @(negedge clk);
        addr[1] = 8'h30; rstr[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstr[1] = 1'b0;
        ra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rack[1]) ra++;
        end
        chk("abort_no_rack", ra, 0);
        xfer(1, 0, 8'h7E, 32'h0, 6, acks, first, rd, pl);
        chk("abort_errcnt", rd, 32'h0);
        chk("r1_latency", first, 4);

        // async reset with instance 0 in its ack cycle and instance 1 still waiting
        xfer(0, 1, 8'h00, 32'hFFFFFFFF, 3, acks, first, rd, pl);
        @(negedge clk);
        addr[1] = 8'h00; wdata[1] = 32'h1; wstr[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr[0] = 8'h00; wdata[0] = 32'h2; wstr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_wack", wack[0], 1'b1);
        chk("pre_rst_ctrl", ctrl_out[0][31:0], 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wack0", wack[0], 1'b0);
        chk("rst_ctrl0", ctrl_out[0][31:0], 32'h0);
        chk("rst_ctrl1", ctrl_out[1][31:0], 32'h0);
        chk("rst_wack1", wack[1], 1'b0);
        wstr[0] = 1'b0;
        wstr[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wa = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wack[0] || rack[0] || wack[1] || rack[1]) wa++;
        end
        chk("post_rst_quiet", wa, 0);
        xfer(0, 1, 8'h00, 32'h3, 3, acks, first, rd, pl);
        chk("post_rst_acks", acks, 1);
        chk("post_rst_ctrl", ctrl_out[0][31:0], 32'h3);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
